// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: FSM states and the
// default geometry used by reg_file_mp and rf_scoreboard.
package rf_pkg;

  // Controller states: INIT sweeps every entry to zero, RUN is normal operation.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Default parameter values.
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_ZERO_REG = 1;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when an AHB load is
// issued for that register and cleared when the AHB load data returns.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(2**ADDR_W)-1:0] pend_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next scoreboard value: clear first, then set, so a same-cycle set wins.
  always_comb begin
    // NOTE: blocking assignments here on purpose -- later statements override
    // earlier ones, which is exactly how set-over-clear priority is expressed.
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  // Scoreboard state, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all clocked state so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend_vec = pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with a core write port, an AHB load-return write
// port, write-through reads, a pending-load scoreboard and a post-reset
// clear sweep of the array.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_we,
  input  logic [ADDR_W-1:0]        core_waddr,
  input  logic [DATA_W-1:0]        core_wdata,
  input  logic                     core_wsuppress,
  input  logic                     ahb_we,
  input  logic [ADDR_W-1:0]        ahb_waddr,
  input  logic [DATA_W-1:0]        ahb_wdata,
  input  logic                     ahb_pend_set,
  input  logic [ADDR_W-1:0]        ahb_pend_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [(2**ADDR_W)-1:0]   pend_vec,
  output logic                     collision,
  output logic                     init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic core_req;
  logic ahb_req;
  logic same_addr;
  logic core_commit;
  logic ahb_commit;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State and sweep counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: INIT walks cnt through every entry, then hands over to RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign run       = (state_q == RF_RUN);
  assign init_done = run;

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------

  assign core_req  = run & core_we & ~core_wsuppress;
  assign ahb_req   = run & ahb_we;
  assign same_addr = (core_waddr == ahb_waddr);

  // Address 0 is hard-wired to zero when ZERO_REG is set; AHB beats core on
  // an address clash.
  assign ahb_commit  = ahb_req & ~((ZERO_REG != 0) && (ahb_waddr == '0));
  assign core_commit = core_req & ~(ahb_req & same_addr)
                     & ~((ZERO_REG != 0) && (core_waddr == '0));

  // Array update: zero one entry per cycle while sweeping, otherwise apply
  // the committed writes (their addresses never coincide).
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; it is cleared by the INIT sweep,
    // which keeps it mappable onto plain RAM/flop arrays without reset nets.
    if (state_q == RF_INIT) begin
      mem[cnt_q] <= '0;
    end else begin
      if (core_commit) mem[core_waddr] <= core_wdata;
      if (ahb_commit)  mem[ahb_waddr]  <= ahb_wdata;
    end
  end

  // One-cycle pulse whenever a live core write lost to an AHB write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= core_req & ahb_req & same_addr;
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard
  // ---------------------------------------------------------------------------

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (run & ahb_pend_set),
    .set_addr (ahb_pend_addr),
    .clr_en   (ahb_req),
    .clr_addr (ahb_waddr),
    .pend_vec (pend_vec)
  );

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Write-through read: AHB data, then core data, then the stored value;
    // forced to zero while sweeping and for the hard-wired zero entry.
    always_comb begin
      data = mem[addr];
      if (!run) begin
        data = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if (ahb_commit && (ahb_waddr == addr)) begin
        data = ahb_wdata;
      end else if (core_commit && (core_waddr == addr)) begin
        data = core_wdata;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i] = run & pend_vec[addr] & ~(ahb_we & (ahb_waddr == addr));
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 reads 0 and ignores writes.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset. The ports are named clk and rst, and this polarity and synchronicity are fixed.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 core_we  in  1  core write enable.
REQ-009 core_waddr  in  ADDR_W  core write address.
REQ-010 core_wdata  in  DATA_W  core write data.
REQ-011 core_wsuppress  in  1  when 1, core write is cancelled.
REQ-012 ahb_we  in  1  AHB load-return write enable.
REQ-013 ahb_waddr  in  ADDR_W  AHB write address.
REQ-014 ahb_wdata  in  DATA_W  AHB write data.
REQ-015 ahb_pend_set  in  1  marks ahb_pend_addr as awaiting an AHB load.
REQ-016 ahb_pend_addr  in  ADDR_W  register to mark pending.
REQ-017 rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-018 rd_data  out  NUM_RD*DATA_W  packed combinational read data.
REQ-019 rd_busy  out  NUM_RD  port i target pending and not being returned this cycle.
REQ-020 pend_vec  out  DEPTH  current pending scoreboard.
REQ-021 collision  out  1  registered one-cycle pulse: a core write was dropped for an AHB address clash.
REQ-022 init_done  out  1  high once the clear sweep is finished.

Function
REQ-023 The FSM SHALL have two states. INIT clears entry cnt to 0 each cycle, with cnt running 0..DEPTH-1, then moves to RUN. RUN holds until rst.
REQ-024 INIT SHALL take exactly DEPTH cycles, and init_done SHALL rise on the first RUN cycle.
REQ-025 In INIT, all writes and ahb_pend_set SHALL be ignored, rd_data SHALL be 0 and rd_busy SHALL be 0.
REQ-026 The core write SHALL commit at the clock edge only when core_we=1, core_wsuppress=0 and state is RUN.
REQ-027 The AHB write SHALL commit at the clock edge when ahb_we=1 and state is RUN.
REQ-028 When both writes target the same address, the AHB write SHALL win, the core write SHALL be dropped and collision SHALL pulse the next cycle.
REQ-029 Writes to different addresses SHALL commit in the same cycle.
REQ-030 When ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and pend_vec[0] SHALL stay 0.
REQ-031 Reads SHALL be write-through: a same-cycle committing write to rd_addr SHALL be returned on rd_data, with AHB data taking precedence over core data.
REQ-032 ahb_we to address a SHALL clear pend_vec[a]; ahb_pend_set to a SHALL set it. If both hit the same address in one cycle, set SHALL win.
REQ-033 rd_busy[i] SHALL equal pend_vec[rd_addr_i] AND NOT (ahb_we AND ahb_waddr==rd_addr_i).
REQ-034 A core write to a pending register SHALL commit and SHALL leave the pending bit unchanged.

Reset
REQ-035 rst assertion at any time SHALL immediately force: state INIT, cnt=0, pend_vec=0, collision=0, init_done=0.
REQ-036 Register contents SHALL NOT be reset asynchronously; they are cleared only by the INIT sweep.
REQ-037 After rst deasserts, the sweep SHALL restart from entry 0, including when rst arrives mid-sweep.

Structure
REQ-038 A shared package rf_pkg SHALL hold the state enum (RF_INIT, RF_RUN) and the default parameter constants.
REQ-039 A single sub-module rf_scoreboard SHALL own pend_vec and the set/clear logic. The array, FSM, write arbitration and read bypass SHALL sit in the top module.

Verification
REQ-040 Reset sequence: pulse rst, hold reads at 5 -> init_done rises after exactly 32 cycles, and rd_data reads 0 throughout.
REQ-041 Same-address collision: core and AHB both write addr 7 (core 0xAAAA_AAAA, AHB 0x1234_5678) -> next read 0x1234_5678, collision pulses for one cycle.
REQ-042 Write-through bypass: core writes 0xDEAD_BEEF to addr 3 while port 1 reads addr 3 -> rd_data port 1 shows 0xDEAD_BEEF in the same cycle.
REQ-043 Zero register: write 0xFFFF_FFFF to addr 0 and ahb_pend_set to 0 -> reads 0, pend_vec[0]=0.
REQ-044 Scoreboard: set addr 9, read it -> rd_busy=1. Return AHB 0x55 to addr 9 -> rd_busy=0 and data 0x55 the same cycle, and the bit clears at the next edge.
REQ-045 Mid-sweep reset: assert rst at INIT cycle 10 -> init_done=0, and a full 32-cycle sweep restarts after release.
